rst_sequencer: RTL and testbench

Staged reset-release controller placed directly downstream of the per-domain reset synchronizer. It takes the already-synchronized reset and de-asserts one active-high reset per downstream domain, in fixed index order. Each release waits a programmable hold time, and each subsequent release waits for a READY acknowledge from the previously released domain, with a timeout. A software reset request restarts the whole sequence without a global reset.

---
 rtl/rst_seq_pkg.sv | 19 +
 rtl/rst_seq_timer.sv | 23 ++
 rtl/rst_sequencer.sv | 144 ++++++++++++++
 tb/tb_rst_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staged reset-release sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  // Widest domain vector supported; the top slices what it needs.
  localparam int MAX_DOMAINS = 32;
  localparam logic [MAX_DOMAINS-1:0] RST_ALL = '1;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Up-counter with clear/enable and terminal match; serves both the hold and
// the READY-timeout phases of the sequencer.
module rst_seq_timer #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [CNT_WIDTH-1:0] i_cmp,
  output logic                 o_match
);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST || i_clr) r_cnt <= '0;
    else if (i_en)    r_cnt <= r_cnt + CNT_WIDTH'(1);
  end

  assign o_match = (r_cnt == i_cmp);

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset-release controller: releases one domain reset at a time in
// ascending order, gated by a hold time and the previous domain's READY.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int RDY_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 8,
  localparam int IW         = idx_width(NUM_DOMAINS)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  input  logic [NUM_DOMAINS-1:0] READY,
  output logic [NUM_DOMAINS-1:0] RST_OUT,
  output logic                   SEQ_DONE,
  output logic                   TIMEOUT_ERR,
  output logic [IW-1:0]          ERR_IDX
);

  localparam int MAXV = (HOLD_CYCLES > RDY_TIMEOUT) ? HOLD_CYCLES : RDY_TIMEOUT;
  localparam logic [CNT_WIDTH-1:0]   HOLD_M1 = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   TO_M1   = CNT_WIDTH'(RDY_TIMEOUT - 1);
  localparam logic [IW-1:0]          LAST    = IW'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] ALL1    = RST_ALL[NUM_DOMAINS-1:0];

  generate
    if (NUM_DOMAINS < 1 || NUM_DOMAINS > MAX_DOMAINS) begin : g_bad_nd
      $error("rst_sequencer: NUM_DOMAINS out of range");
    end
    if (HOLD_CYCLES < 1 || RDY_TIMEOUT < 1) begin : g_bad_time
      $error("rst_sequencer: HOLD_CYCLES and RDY_TIMEOUT must be >= 1");
    end
    if (CNT_WIDTH < 1 || (CNT_WIDTH < 31 && MAXV > (1 << CNT_WIDTH) - 1)) begin : g_bad_cw
      $error("rst_sequencer: CNT_WIDTH too small for HOLD_CYCLES/RDY_TIMEOUT");
    end
  endgenerate

  state_e                 r_state, w_nxt;
  logic [IW-1:0]          r_idx, w_idx_n;
  logic [NUM_DOMAINS-1:0] r_rst_out, w_rst_n;
  logic                   r_done, w_done_n;
  logic                   r_err, w_err_n;
  logic [IW-1:0]          r_eidx, w_eidx_n;
  logic                   w_clr, w_en, w_match;
  logic [CNT_WIDTH-1:0]   w_cmp;

  assign w_cmp = (r_state == S_HOLD) ? HOLD_M1 : TO_M1;

  rst_seq_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_cmp   (w_cmp),
    .o_match (w_match)
  );

  always_comb begin
    w_nxt    = r_state;
    w_idx_n  = r_idx;
    w_rst_n  = r_rst_out;
    w_done_n = r_done;
    w_err_n  = r_err;
    w_eidx_n = r_eidx;
    w_clr    = 1'b0;
    w_en     = 1'b0;
    if (SW_RST_REQ) begin
      w_nxt    = S_HOLD;
      w_idx_n  = '0;
      w_rst_n  = ALL1;
      w_done_n = 1'b0;
      w_err_n  = 1'b0;
      w_eidx_n = '0;
      w_clr    = 1'b1;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (w_match) begin
            w_rst_n[r_idx] = 1'b0;
            w_clr          = 1'b1;
            w_nxt          = S_WAIT;
          end else begin
            w_en = 1'b1;
          end
        end
        S_WAIT: begin
          // READY on the timeout edge still counts as a successful ack.
          if (READY[r_idx]) begin
            if (r_idx == LAST) begin
              w_nxt    = S_DONE;
              w_done_n = 1'b1;
            end else begin
              w_idx_n = r_idx + IW'(1);
              w_clr   = 1'b1;
              w_nxt   = S_HOLD;
            end
          end else if (w_match) begin
            w_nxt    = S_ERR;
            w_err_n  = 1'b1;
            w_eidx_n = r_idx;
            w_rst_n  = ALL1;
          end else begin
            w_en = 1'b1;
          end
        end
        S_DONE: begin
          w_rst_n  = '0;
          w_done_n = 1'b1;
        end
        S_ERR: begin
          w_rst_n = ALL1;
          w_err_n = 1'b1;
        end
        default: w_nxt = S_HOLD;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_HOLD;
      r_idx     <= '0;
      r_rst_out <= ALL1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_eidx    <= '0;
    end else begin
      r_state   <= w_nxt;
      r_idx     <= w_idx_n;
      r_rst_out <= w_rst_n;
      r_done    <= w_done_n;
      r_err     <= w_err_n;
      r_eidx    <= w_eidx_n;
    end
  end

  assign RST_OUT     = r_rst_out;
  assign SEQ_DONE    = r_done;
  assign TIMEOUT_ERR = r_err;
  assign ERR_IDX     = r_eidx;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with default parameters.
module tb_rst_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SW_RST_REQ = 1'b0;
  logic [3:0] READY = 4'hF;
  logic [3:0] RST_OUT;
  logic       SEQ_DONE;
  logic       TIMEOUT_ERR;
  logic [1:0] ERR_IDX;

  int n_vec = 0;
  int n_err = 0;
  int edge_no = 0;

  typedef struct {
    int         e;
    logic [3:0] ro;
    logic       d;
    logic       te;
  } vec_t;

  vec_t tbl[10];

  rst_sequencer dut (
    .CLK(CLK), .RST(RST), .SW_RST_REQ(SW_RST_REQ), .READY(READY),
    .RST_OUT(RST_OUT), .SEQ_DONE(SEQ_DONE), .TIMEOUT_ERR(TIMEOUT_ERR),
    .ERR_IDX(ERR_IDX)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    edge_no++;
    @(negedge CLK);
  endtask

  task automatic go_to(input int target);
    while (edge_no < target) step();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_no, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ro, input logic d,
                         input logic te, input logic [1:0] ei);
    chk({tag, ".RST_OUT"}, int'(RST_OUT), int'(ro));
    chk({tag, ".SEQ_DONE"}, int'(SEQ_DONE), int'(d));
    chk({tag, ".TIMEOUT_ERR"}, int'(TIMEOUT_ERR), int'(te));
    chk({tag, ".ERR_IDX"}, int'(ERR_IDX), int'(ei));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    SW_RST_REQ = 1'b0;
    step();
    step();
    chk_all("reset", 4'hF, 1'b0, 1'b0, 2'd0);
    RST = 1'b0;
    edge_no = 0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 10; i++) begin
      go_to(tbl[i].e);
      chk({tag, ".RST_OUT"}, int'(RST_OUT), int'(tbl[i].ro));
      chk({tag, ".SEQ_DONE"}, int'(SEQ_DONE), int'(tbl[i].d));
      chk({tag, ".TIMEOUT_ERR"}, int'(TIMEOUT_ERR), int'(tbl[i].te));
    end
  endtask

  initial begin
    tbl[0] = '{e: 1,  ro: 4'b1111, d: 1'b0, te: 1'b0};
    tbl[1] = '{e: 15, ro: 4'b1111, d: 1'b0, te: 1'b0};
    tbl[2] = '{e: 16, ro: 4'b1110, d: 1'b0, te: 1'b0};
    tbl[3] = '{e: 32, ro: 4'b1110, d: 1'b0, te: 1'b0};
    tbl[4] = '{e: 33, ro: 4'b1100, d: 1'b0, te: 1'b0};
    tbl[5] = '{e: 49, ro: 4'b1100, d: 1'b0, te: 1'b0};
    tbl[6] = '{e: 50, ro: 4'b1000, d: 1'b0, te: 1'b0};
    tbl[7] = '{e: 66, ro: 4'b1000, d: 1'b0, te: 1'b0};
    tbl[8] = '{e: 67, ro: 4'b0000, d: 1'b0, te: 1'b0};
    tbl[9] = '{e: 68, ro: 4'b0000, d: 1'b1, te: 1'b0};

    // Nominal sequence with READY tied high.
    READY = 4'hF;
    do_reset();
    run_table("nominal");

    // READY[0] dropping after completion must not disturb anything.
    READY = 4'b1110;
    go_to(80);
    chk_all("post_done", 4'b0000, 1'b1, 1'b0, 2'd0);
    READY = 4'h0;
    go_to(90);
    chk_all("post_done_rdy0", 4'b0000, 1'b1, 1'b0, 2'd0);

    // Domain 1 never acknowledges.
    READY = 4'b1101;
    do_reset();
    go_to(287);
    chk_all("to_pre", 4'b1100, 1'b0, 1'b0, 2'd0);
    go_to(288);
    chk_all("to_hit", 4'b1111, 1'b0, 1'b1, 2'd1);
    READY = 4'hF;
    go_to(788);
    chk_all("err_sticky", 4'b1111, 1'b0, 1'b1, 2'd1);

    // Software restart out of the error state.
    SW_RST_REQ = 1'b1;
    step();
    SW_RST_REQ = 1'b0;
    chk_all("sw_rst", 4'b1111, 1'b0, 1'b0, 2'd0);
    edge_no = 0;
    run_table("sw_replay");

    // RST pulse mid-sequence after domains 0 and 1 released.
    do_reset();
    go_to(40);
    chk_all("mid_pre", 4'b1100, 1'b0, 1'b0, 2'd0);
    RST = 1'b1;
    step();
    chk_all("mid_rst", 4'b1111, 1'b0, 1'b0, 2'd0);
    RST = 1'b0;
    edge_no = 0;
    run_table("rst_replay");

    // SW request mid-sequence reasserts everything too.
    do_reset();
    go_to(55);
    SW_RST_REQ = 1'b1;
    step();
    SW_RST_REQ = 1'b0;
    chk_all("mid_sw", 4'b1111, 1'b0, 1'b0, 2'd0);

    // READY[2] arrives on the exact timeout edge.
    READY = 4'b1011;
    do_reset();
    go_to(304);
    chk_all("race_pre", 4'b1000, 1'b0, 1'b0, 2'd0);
    READY = 4'hF;
    go_to(305);
    chk_all("race_edge", 4'b1000, 1'b0, 1'b0, 2'd0);
    go_to(320);
    chk_all("race_hold", 4'b1000, 1'b0, 1'b0, 2'd0);
    go_to(321);
    chk_all("race_rel3", 4'b0000, 1'b0, 1'b0, 2'd0);
    go_to(322);
    chk_all("race_done", 4'b0000, 1'b1, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
